// File: rtl/tach_pkg.sv
// rtl/tach_pkg.sv - shared widths, saturation helper and filter state for the tachometer chain
package tach_pkg;

    localparam int SIGNAL_W   = 9;
    localparam int SIGNAL_MAX = 511;
    localparam int EDGE_CNT_W = 10;

    typedef enum logic {
        FILT_LOW,
        FILT_HIGH
    } filt_state_t;

    function automatic logic [SIGNAL_W-1:0] sat_signal(input logic [EDGE_CNT_W:0] total);
        if (total > (EDGE_CNT_W+1)'(SIGNAL_MAX)) begin
            return SIGNAL_W'(SIGNAL_MAX);
        end
        return total[SIGNAL_W-1:0];
    endfunction

endpackage

// File: rtl/tach_input_filter.sv
// rtl/tach_input_filter.sv - sensor synchroniser and stability filter producing a rise strobe
module tach_input_filter
    import tach_pkg::*;
#(
    parameter int FILTER_CYCLES = 16
) (
    input  logic Clk,
    input  logic nReset,
    input  logic SensorIn,
    output logic filt,
    output logic rise
);

    localparam logic [7:0] STAB_LAST = 8'(FILTER_CYCLES - 1);

    logic        s_meta;
    logic        s_sync;
    logic [7:0]  stab_cnt;
    logic [7:0]  stab_cnt_nxt;
    logic        rise_nxt;
    filt_state_t state;
    filt_state_t state_nxt;

    always_ff @(posedge Clk) begin
        if (!nReset) begin
            s_meta   <= 1'b0;
            s_sync   <= 1'b0;
            state    <= FILT_LOW;
            stab_cnt <= '0;
            rise     <= 1'b0;
        end else begin
            s_meta   <= SensorIn;
            s_sync   <= s_meta;
            state    <= state_nxt;
            stab_cnt <= stab_cnt_nxt;
            rise     <= rise_nxt;
        end
    end

    // The counter only runs while s_sync disagrees with the filtered level.
    always_comb begin
        state_nxt    = state;
        stab_cnt_nxt = '0;
        rise_nxt     = 1'b0;
        case (state)
            FILT_LOW: begin
                if (s_sync) begin
                    if (stab_cnt == STAB_LAST) begin
                        state_nxt = FILT_HIGH;
                        rise_nxt  = 1'b1;
                    end else begin
                        stab_cnt_nxt = stab_cnt + 8'd1;
                    end
                end
            end
            FILT_HIGH: begin
                if (!s_sync) begin
                    if (stab_cnt == STAB_LAST) begin
                        state_nxt = FILT_LOW;
                    end else begin
                        stab_cnt_nxt = stab_cnt + 8'd1;
                    end
                end
            end
            default: state_nxt = FILT_LOW;
        endcase
    end

    assign filt = (state == FILT_HIGH);

endmodule

// File: rtl/tach_pulse_counter.sv
// rtl/tach_pulse_counter.sv - counts filtered sensor edges per gate window and publishes Signal
module tach_pulse_counter
    import tach_pkg::*;
#(
    parameter int GATE_CYCLES   = 5000000,
    parameter int FILTER_CYCLES = 16
) (
    input  logic                Clk,
    input  logic                nReset,
    input  logic                SensorIn,
    output logic [SIGNAL_W-1:0] Signal,
    output logic                Valid,
    output logic                Overflow
);

    localparam int GATE_W = $clog2(GATE_CYCLES);

    logic                  filt_unused;
    logic                  rise;
    logic [GATE_W-1:0]     gate_cnt;
    logic                  gate_end;
    logic [EDGE_CNT_W-1:0] edge_cnt;
    logic [EDGE_CNT_W:0]   edge_total;

    tach_input_filter #(
        .FILTER_CYCLES(FILTER_CYCLES)
    ) u_filter (
        .Clk     (Clk),
        .nReset  (nReset),
        .SensorIn(SensorIn),
        .filt    (filt_unused),
        .rise    (rise)
    );

    assign gate_end = (gate_cnt == GATE_W'(GATE_CYCLES - 1));

    // A rise landing on the gate-end cycle still belongs to the closing window.
    assign edge_total = {1'b0, edge_cnt} + {{EDGE_CNT_W{1'b0}}, rise};

    always_ff @(posedge Clk) begin
        if (!nReset) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
            Signal   <= '0;
            Valid    <= 1'b0;
            Overflow <= 1'b0;
        end else begin
            gate_cnt <= gate_end ? '0 : gate_cnt + 1'b1;
            Valid    <= gate_end;
            if (gate_end) begin
                Signal   <= sat_signal(edge_total);
                Overflow <= (edge_total > (EDGE_CNT_W+1)'(SIGNAL_MAX));
                edge_cnt <= '0;
            end else if (rise && (edge_cnt != {EDGE_CNT_W{1'b1}})) begin
                edge_cnt <= edge_cnt + 1'b1;
            end
        end
    end

endmodule
